// File: rtl/uart_cmd_responder_if.sv
// Bundles the UART byte handshake and memory bus seen by the command responder.
// master = responder side, slave = UART pair / memory side.
interface uart_cmd_responder_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic              tx_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              frame_err;
    logic [7:0]        drop_cnt;

    modport master (
        input  rx_data, rx_valid, tx_busy, mem_rdata, mem_ack,
        output tx_byte, tx_start, mem_req, mem_we, mem_addr, mem_wdata, frame_err, drop_cnt
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, mem_rdata, mem_ack,
        input  tx_byte, tx_start, mem_req, mem_we, mem_addr, mem_wdata, frame_err, drop_cnt
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Host command responder: decodes READ/WRITE byte frames from the UART receiver,
// performs a single memory access and returns the reply through the UART transmitter.
module uart_cmd_responder #(
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_responder_if.master bus
);
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h41;
    localparam logic [7:0] RSP_NAK = 8'h4E;
    localparam int         TW      = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WDATA, MEM, TX_START, TX_WAIT_HI, TX_WAIT_LO
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        addr_hi_reg, addr_hi_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              mem_we_reg, mem_we_next;
    logic              mem_req_reg, mem_req_next;
    logic [7:0]        tx_byte_reg, tx_byte_next;
    logic [7:0]        reply_hi_reg, reply_hi_next;
    logic              more_reg, more_next;
    logic              frame_err_reg, frame_err_next;
    logic [7:0]        drop_cnt_reg, drop_cnt_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [15:0]       full_addr;

    assign full_addr = {addr_hi_reg, bus.rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_hi_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_req_reg   <= 1'b0;
            tx_byte_reg   <= '0;
            reply_hi_reg  <= '0;
            more_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            drop_cnt_reg  <= '0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_hi_reg   <= addr_hi_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            mem_req_reg   <= mem_req_next;
            tx_byte_reg   <= tx_byte_next;
            reply_hi_reg  <= reply_hi_next;
            more_reg      <= more_next;
            frame_err_reg <= frame_err_next;
            drop_cnt_reg  <= drop_cnt_next;
            timer_reg     <= timer_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_hi_next   = addr_hi_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = mem_we_reg;
        mem_req_next   = mem_req_reg;
        tx_byte_next   = tx_byte_reg;
        reply_hi_next  = reply_hi_reg;
        more_next      = more_reg;
        frame_err_next = 1'b0;
        drop_cnt_next  = drop_cnt_reg;
        timer_next     = timer_reg;

        // Bytes arriving while busy with memory or the reply are overruns.
        if (bus.rx_valid && (state_reg == MEM || state_reg == TX_START ||
                             state_reg == TX_WAIT_HI || state_reg == TX_WAIT_LO)) begin
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (bus.rx_valid) begin
                    timer_next = '0;
                    if (bus.rx_data == CMD_RD || bus.rx_data == CMD_WR) begin
                        mem_we_next = (bus.rx_data == CMD_WR);
                        state_next  = ADDR_HI;
                    end else begin
                        tx_byte_next   = RSP_NAK;
                        more_next      = 1'b0;
                        frame_err_next = 1'b1;
                        state_next     = TX_START;
                    end
                end
            end
            ADDR_HI, ADDR_LO, WDATA: begin
                // A byte in the expiry cycle wins over the timeout.
                if (bus.rx_valid) begin
                    timer_next = '0;
                    if (state_reg == ADDR_HI) begin
                        addr_hi_next = bus.rx_data;
                        state_next   = ADDR_LO;
                    end else if (state_reg == ADDR_LO) begin
                        mem_addr_next = full_addr[ADDR_W-1:0];
                        if (mem_we_reg) begin
                            state_next = WDATA;
                        end else begin
                            mem_req_next = 1'b1;
                            state_next   = MEM;
                        end
                    end else begin
                        mem_wdata_next = bus.rx_data;
                        mem_req_next   = 1'b1;
                        state_next     = MEM;
                    end
                end else if (timer_reg == TW'(TIMEOUT_CLKS - 1)) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    mem_req_next  = 1'b0;
                    reply_hi_next = bus.mem_rdata;
                    more_next     = !mem_we_reg;
                    tx_byte_next  = RSP_ACK;
                    state_next    = TX_START;
                end
            end
            TX_START: begin
                if (!bus.tx_busy) begin
                    state_next = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_next = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (more_reg) begin
                        more_next    = 1'b0;
                        tx_byte_next = reply_hi_reg;
                        state_next   = TX_START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_start is decoded from state so the first reply byte goes out the clock after mem_ack.
    assign bus.tx_start  = (state_reg == TX_START) && !bus.tx_busy;
    assign bus.tx_byte   = tx_byte_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with behavioural UART transmitter and memory models.
module tb_uart_cmd_responder;
    localparam int T_OUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    uart_cmd_responder_if #(.ADDR_W(16)) bus ();

    uart_cmd_responder #(.ADDR_W(16), .TIMEOUT_CLKS(T_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the clock after tx_start, stays high tx_len clocks.
    logic tx_busy_m = 1'b0;
    int   tx_len    = 8;
    int   tx_cnt    = 0;
    assign bus.tx_busy = tx_busy_m;
    always @(posedge clk) begin
        if (bus.tx_start && !tx_busy_m) begin
            tx_busy_m <= 1'b1;
            tx_cnt    <= tx_len;
        end else if (tx_busy_m) begin
            if (tx_cnt <= 1) tx_busy_m <= 1'b0;
            else tx_cnt <= tx_cnt - 1;
        end
    end

    // Memory model: ack pulse ack_lat clocks after mem_req rises.
    logic       ack_m     = 1'b0;
    logic [7:0] rdata_m   = 8'h00;
    logic [7:0] rdata_val = 8'h00;
    int         ack_lat   = 3;
    int         mcnt      = 0;
    bit         mbusy     = 1'b0;
    assign bus.mem_ack   = ack_m;
    assign bus.mem_rdata = rdata_m;
    always @(posedge clk) begin
        ack_m <= 1'b0;
        if (bus.mem_req && !ack_m && !mbusy) begin
            if (ack_lat <= 1) begin
                ack_m   <= 1'b1;
                rdata_m <= rdata_val;
            end else begin
                mbusy <= 1'b1;
                mcnt  <= ack_lat - 1;
            end
        end else if (mbusy) begin
            if (mcnt <= 1) begin
                ack_m   <= 1'b1;
                rdata_m <= rdata_val;
                mbusy   <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    // Observation log, sampled mid-cycle.
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          ack_cyc  = -1;
    int          ferr_cnt = 0;
    int          req_cnt  = 0;
    logic        last_we  = 1'b0;
    logic [15:0] last_addr  = 16'h0;
    logic [7:0]  last_wdata = 8'h0;
    logic        prev_req   = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.tx_start) begin
            tx_q.push_back(bus.tx_byte);
            tx_cyc_q.push_back(cyc);
        end
        if (bus.mem_ack) ack_cyc = cyc;
        if (bus.frame_err) ferr_cnt++;
        if (bus.mem_req && !prev_req) begin
            req_cnt++;
            last_we    = bus.mem_we;
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
        end
        prev_req = bus.mem_req;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for n reply bytes past base and for the transmitter to go idle.
    task automatic wait_tx(input int base, input int n, input int max_cyc, input string name);
        int k = 0;
        while ((tx_q.size() - base) < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        while (tx_busy_m && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        tests++;
        if (k >= max_cyc) begin
            fails++;
            $display("FAIL %s wait: got %0d bytes, required %0d within %0d clks", name, tx_q.size() - base, n, max_cyc);
        end
    endtask

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte: got %h required 00", bus.tx_byte); end
        tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b required 0", bus.tx_start); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b required 0", bus.mem_req); end
        tests++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h required 0000", bus.mem_addr); end
        tests++; if (bus.drop_cnt !== 8'h00) begin fails++; $display("FAIL reset_drop_cnt: got %h required 00", bus.drop_cnt); end
        tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset done");
    endtask

    task automatic test_write();
        int qb = tx_q.size();
        int rb = req_cnt;
        int fb = ferr_cnt;
        ack_lat = 3;
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL wr_req_early: got %b required 0", bus.mem_req); end
        send_byte(8'hA5);
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL wr_req_latency: got %b required 1", bus.mem_req); end
        wait_tx(qb, 1, 200, "write");
        tests++; if (req_cnt - rb !== 1) begin fails++; $display("FAIL wr_req_count: got %0d required 1", req_cnt - rb); end
        tests++; if (last_we !== 1'b1) begin fails++; $display("FAIL wr_we: got %b required 1", last_we); end
        tests++; if (last_addr !== 16'h1234) begin fails++; $display("FAIL wr_addr: got %h required 1234", last_addr); end
        tests++; if (last_wdata !== 8'hA5) begin fails++; $display("FAIL wr_wdata: got %h required A5", last_wdata); end
        tests++; if (tx_q.size() - qb !== 1) begin fails++; $display("FAIL wr_reply_len: got %0d required 1", tx_q.size() - qb); end
        tests++; if (tx_q[qb] !== 8'h41) begin fails++; $display("FAIL wr_reply: got %h required 41", tx_q[qb]); end
        tests++; if (tx_cyc_q[qb] !== ack_cyc + 1) begin fails++; $display("FAIL wr_tx_latency: got cycle %0d required %0d", tx_cyc_q[qb], ack_cyc + 1); end
        tests++; if (ferr_cnt - fb !== 0) begin fails++; $display("FAIL wr_frame_err: got %0d pulses required 0", ferr_cnt - fb); end
        $display("[TB] write addr=%h data=%h reply=%h", last_addr, last_wdata, tx_q[qb]);
    endtask

    task automatic test_read(input logic [15:0] addr, input logic [7:0] data, input string name);
        int qb = tx_q.size();
        int rb = req_cnt;
        rdata_val = data;
        ack_lat   = 2;
        send_byte(8'h52);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        wait_tx(qb, 2, 300, name);
        tests++; if (req_cnt - rb !== 1) begin fails++; $display("FAIL %s_req_count: got %0d required 1", name, req_cnt - rb); end
        tests++; if (last_we !== 1'b0) begin fails++; $display("FAIL %s_we: got %b required 0", name, last_we); end
        tests++; if (last_addr !== addr) begin fails++; $display("FAIL %s_addr: got %h required %h", name, last_addr, addr); end
        tests++; if (tx_q.size() - qb !== 2) begin fails++; $display("FAIL %s_reply_len: got %0d required 2", name, tx_q.size() - qb); end
        tests++; if (tx_q[qb] !== 8'h41) begin fails++; $display("FAIL %s_reply0: got %h required 41", name, tx_q[qb]); end
        tests++; if (tx_q[qb+1] !== data) begin fails++; $display("FAIL %s_reply1: got %h required %h", name, tx_q[qb+1], data); end
        $display("[TB] %s addr=%h reply=%h %h", name, last_addr, tx_q[qb], tx_q[qb+1]);
    endtask

    task automatic test_bad_cmd();
        int qb = tx_q.size();
        int rb = req_cnt;
        int fb = ferr_cnt;
        send_byte(8'h7F);
        wait_tx(qb, 1, 200, "bad_cmd");
        tests++; if (tx_q.size() - qb !== 1) begin fails++; $display("FAIL bad_reply_len: got %0d required 1", tx_q.size() - qb); end
        tests++; if (tx_q[qb] !== 8'h4E) begin fails++; $display("FAIL bad_reply: got %h required 4E", tx_q[qb]); end
        tests++; if (ferr_cnt - fb !== 1) begin fails++; $display("FAIL bad_frame_err: got %0d pulses required 1", ferr_cnt - fb); end
        tests++; if (req_cnt - rb !== 0) begin fails++; $display("FAIL bad_mem_req: got %0d required 0", req_cnt - rb); end
        $display("[TB] bad cmd 7F reply=%h", tx_q[qb]);
        test_read(16'h0020, 8'h5A, "read_after_bad");
    endtask

    task automatic test_timeout();
        int qb = tx_q.size();
        int rb = req_cnt;
        int fb = ferr_cnt;
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (T_OUT - 3) @(negedge clk);
        tests++; if (ferr_cnt - fb !== 0) begin fails++; $display("FAIL to_early: got %0d pulses required 0", ferr_cnt - fb); end
        repeat (6) @(negedge clk);
        tests++; if (ferr_cnt - fb !== 1) begin fails++; $display("FAIL to_frame_err: got %0d pulses required 1", ferr_cnt - fb); end
        tests++; if (req_cnt - rb !== 0) begin fails++; $display("FAIL to_mem_req: got %0d required 0", req_cnt - rb); end
        tests++; if (tx_q.size() - qb !== 0) begin fails++; $display("FAIL to_reply: got %0d bytes required 0", tx_q.size() - qb); end
        $display("[TB] timeout after 52 00 frame_err=%0d", ferr_cnt - fb);
        test_read(16'h0001, 8'h77, "read_after_timeout");
    endtask

    task automatic test_overrun();
        int qb;
        int rb;
        int k = 0;
        do_reset();
        qb = tx_q.size();
        rb = req_cnt;
        tx_len    = 1000;
        ack_lat   = 1;
        rdata_val = 8'hC3;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h02);
        while (tx_q.size() == qb && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests++; if (tx_q.size() - qb !== 1) begin fails++; $display("FAIL ovr_first_tx: got %0d bytes required 1", tx_q.size() - qb); end
        for (int i = 0; i < 5; i++) send_byte(8'h52);
        tests++; if (bus.drop_cnt !== 8'd5) begin fails++; $display("FAIL ovr_drop5: got %0d required 5", bus.drop_cnt); end
        for (int i = 0; i < 295; i++) send_byte(8'h57);
        tests++; if (bus.drop_cnt !== 8'd255) begin fails++; $display("FAIL ovr_saturate: got %0d required 255", bus.drop_cnt); end
        wait_tx(qb, 2, 3000, "overrun");
        tx_len = 8;
        tests++; if (tx_q.size() - qb !== 2) begin fails++; $display("FAIL ovr_reply_len: got %0d required 2", tx_q.size() - qb); end
        tests++; if (tx_q[qb+1] !== 8'hC3) begin fails++; $display("FAIL ovr_reply1: got %h required C3", tx_q[qb+1]); end
        tests++; if (req_cnt - rb !== 1) begin fails++; $display("FAIL ovr_req_count: got %0d required 1", req_cnt - rb); end
        $display("[TB] overrun 300 bytes drop_cnt=%0d", bus.drop_cnt);
    endtask

    task automatic test_reset_mid();
        int qb = tx_q.size();
        int rb = req_cnt;
        int k = 0;
        ack_lat = 20;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h11);
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rm_mem_req_set: got %b required 1", bus.mem_req); end
        repeat (3) @(negedge clk);
        do_reset();
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rm_mem_req: got %b required 0", bus.mem_req); end
        tests++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL rm_mem_addr: got %h required 0000", bus.mem_addr); end
        tests++; if (bus.drop_cnt !== 8'h00) begin fails++; $display("FAIL rm_drop_cnt: got %h required 00", bus.drop_cnt); end
        repeat (40) @(negedge clk);
        tests++; if (tx_q.size() - qb !== 0) begin fails++; $display("FAIL rm_mem_tx: got %0d bytes required 0", tx_q.size() - qb); end
        tests++; if (req_cnt - rb !== 1) begin fails++; $display("FAIL rm_mem_req_count: got %0d required 1", req_cnt - rb); end
        $display("[TB] reset during MEM, replies=%0d", tx_q.size() - qb);

        qb = tx_q.size();
        ack_lat   = 2;
        tx_len    = 20;
        rdata_val = 8'h99;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h08);
        while (!(tx_q.size() > qb && tx_busy_m) && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        do_reset();
        tests++; if (bus.tx_byte !== 8'h00) begin fails++; $display("FAIL rt_tx_byte: got %h required 00", bus.tx_byte); end
        tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL rt_tx_start: got %b required 0", bus.tx_start); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rt_mem_req: got %b required 0", bus.mem_req); end
        repeat (60) @(negedge clk);
        tx_len = 8;
        tests++; if (tx_q.size() - qb !== 1) begin fails++; $display("FAIL rt_tx_count: got %0d bytes required 1", tx_q.size() - qb); end
        tests++; if (tx_q[qb] !== 8'h41) begin fails++; $display("FAIL rt_first_byte: got %h required 41", tx_q[qb]); end
        $display("[TB] reset during TX_WAIT_LO, replies=%0d", tx_q.size() - qb);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(16'h0010, 8'h3C, "read");
        test_bad_cmd();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_read(16'hBEEF, 8'h0F, "read_final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 50000 clks");
        $fatal(1);
    end
endmodule
